// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states and
// instruction field positions.
package core_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OP_W     = 5;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned IMMS_W   = 6;
  localparam int unsigned IMML_W   = 11;
  localparam int unsigned OP_LSB   = 11;
  localparam int unsigned RS_LSB   = 5;
  localparam int unsigned RD_LSB   = 0;
  localparam int unsigned IMMS_LSB = 5;
  localparam int unsigned IMML_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_ADDI   = 5'd2,
    OP_SHLLI  = 5'd3,
    OP_SHRLI  = 5'd4,
    OP_JUMP   = 5'd5,
    OP_JUMPLI = 5'd6,
    OP_JUMPL  = 5'd7,
    OP_JUMPG  = 5'd8,
    OP_JUMPE  = 5'd9,
    OP_JUMPNE = 5'd10,
    OP_CMP    = 5'd11,
    OP_RET    = 5'd12,
    OP_LOAD   = 5'd13,
    OP_LOADI  = 5'd14,
    OP_STORE  = 5'd15,
    OP_MOV    = 5'd16,
    OP_HALT   = 5'd31
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_HALT
  } state_e;

endpackage

// File: rtl/core_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Indices at or beyond NREGS read as zero and drop writes.
module core_regfile
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (32'(waddr) < NREGS)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (32'(raddr_a) < NREGS) ? regs[raddr_a] : '0;
  assign rdata_b = (32'(raddr_b) < NREGS) ? regs[raddr_b] : '0;

endmodule

// File: rtl/multicycle_core.sv
// Parametrised multi-cycle core: FETCH/DECODE/EXECUTE/MEM/HALT over a
// unified memory with a req/ready handshake.
module multicycle_core
  import core_pkg::*;
#(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned MEM_W    = 16,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  input  logic [MEM_W-1:0]  mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, link_q, link_d;
  logic [MEM_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              sf_q, sf_d, zf_q, zf_d, of_q, of_d;
  logic              req_d, we_d, halted_d;
  logic [ADDR_W-1:0] addr_d;
  logic [MEM_W-1:0]  wdata_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata, rf_a, rf_b;

  opcode_e           op;
  logic [IDX_W-1:0]  rs, rd;
  logic [IMMS_W-1:0] imms;
  logic [DATA_W-1:0] imms_ext, diff, shl_res, shr_res;
  logic [ADDR_W-1:0] imml_ext;
  logic              sh_big;

  assign op       = opcode_e'(ir_q[OP_LSB +: OP_W]);
  assign rs       = ir_q[RS_LSB +: IDX_W];
  assign rd       = ir_q[RD_LSB +: IDX_W];
  assign imms     = ir_q[IMMS_LSB +: IMMS_W];
  assign imms_ext = DATA_W'(imms);
  assign imml_ext = ADDR_W'(ir_q[IMML_LSB +: IMML_W]);
  assign diff     = a_q - b_q;
  assign sh_big   = 32'(imms) >= DATA_W;
  assign shl_res  = sh_big ? '0 : (a_q << imms);
  assign shr_res  = sh_big ? '0 : (a_q >> imms);
  assign pc_o     = pc_q;

  core_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rd),
    .rdata_a (rf_a),
    .raddr_b (rs),
    .rdata_b (rf_b),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= ADDR_W'(RESET_PC);
      link_q    <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sf_q      <= 1'b0;
      zf_q      <= 1'b0;
      of_q      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      link_q    <= link_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sf_q      <= sf_d;
      zf_q      <= zf_d;
      of_q      <= of_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      halted    <= halted_d;
    end
  end

  // Next state; request outputs are precomputed from the state being entered
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    link_d   = link_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    sf_d     = sf_q;
    zf_d     = zf_q;
    of_d     = of_q;
    req_d    = mem_req;
    we_d     = mem_we;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    rf_we    = 1'b0;
    rf_wdata = '0;

    case (state_q)
      S_FETCH: begin
        if (mem_req && mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
          req_d   = 1'b0;
        end else begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end
      end
      S_DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD:    begin rf_we = 1'b1; rf_wdata = a_q + b_q; end
          OP_SUB:    begin rf_we = 1'b1; rf_wdata = diff; end
          OP_ADDI:   begin rf_we = 1'b1; rf_wdata = a_q + imms_ext; end
          OP_SHLLI:  begin rf_we = 1'b1; rf_wdata = shl_res; end
          OP_SHRLI:  begin rf_we = 1'b1; rf_wdata = shr_res; end
          OP_MOV:    begin rf_we = 1'b1; rf_wdata = b_q; end
          OP_LOADI:  begin rf_we = 1'b1; rf_wdata = imms_ext; end
          OP_CMP: begin
            sf_d = diff[DATA_W-1];
            zf_d = (diff == '0);
            of_d = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
          end
          OP_JUMP:   pc_d = imml_ext;
          OP_JUMPLI: begin link_d = pc_q; pc_d = imml_ext; end
          OP_JUMPL:  if (sf_q != of_q) pc_d = imml_ext;
          OP_JUMPG:  if ((sf_q == of_q) && !zf_q) pc_d = imml_ext;
          OP_JUMPE:  if (zf_q) pc_d = imml_ext;
          OP_JUMPNE: if (!zf_q) pc_d = imml_ext;
          OP_RET:    pc_d = link_q;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_HALT:   state_d = S_HALT;
          default: ;
        endcase
        if (state_d == S_FETCH) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_d;
        end else if (state_d == S_MEM) begin
          req_d = 1'b1;
          if (op == OP_STORE) begin
            we_d    = 1'b1;
            addr_d  = a_q[ADDR_W-1:0];
            wdata_d = b_q[MEM_W-1:0];
          end else begin
            we_d   = 1'b0;
            addr_d = b_q[ADDR_W-1:0];
          end
        end
      end
      S_MEM: begin
        if (mem_req && mem_ready) begin
          if (op == OP_LOAD) begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(mem_rdata);
          end
          state_d = S_FETCH;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = pc_q;
        end
      end
      S_HALT: req_d = 1'b0;
      default: state_d = S_FETCH;
    endcase

    halted_d = (state_d == S_HALT);
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: memory responder with wait states,
// transaction scoreboard and register/flag spot checks.
module tb_multicycle_core;

  localparam logic [4:0] O_ADD = 5'd0, O_SUB = 5'd1, O_SHLLI = 5'd3, O_SHRLI = 5'd4;
  localparam logic [4:0] O_JUMPLI = 5'd6, O_JUMPL = 5'd7, O_JUMPG = 5'd8, O_CMP = 5'd11;
  localparam logic [4:0] O_RET = 5'd12, O_LOAD = 5'd13, O_LOADI = 5'd14, O_STORE = 5'd15;
  localparam logic [4:0] O_MOV = 5'd16, O_HALT = 5'd31;
  localparam logic [15:0] NOP = 16'h8800;
  localparam logic [23:0] NO_STALL = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ready = 1'b0, halted;
  logic [23:0] mem_addr, pc_o;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[9:0]];

  typedef struct { logic we; logic [23:0] addr; logic [15:0] wdata; } txn_t;
  txn_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int wait_cycles = 0;
  int wcnt = 0;
  logic [23:0] stall_addr = NO_STALL;
  bit          hold_valid = 1'b0;
  logic        held_we;
  logic [23:0] held_addr;
  logic [15:0] held_wdata;
  int c1, c2;

  always #5 clk = ~clk;

  multicycle_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .pc_o      (pc_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ins_r(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs);
    return {op, 1'b0, rs, rd};
  endfunction
  function automatic logic [15:0] ins_i(input logic [4:0] op, input logic [4:0] rd, input logic [5:0] imm);
    return {op, imm, rd};
  endfunction
  function automatic logic [15:0] ins_j(input logic [4:0] op, input logic [10:0] imm);
    return {op, imm};
  endfunction

  task automatic push_txn(input logic we, input logic [23:0] addr, input logic [15:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  // Responder: decides ready at the falling edge, checks and retires accepted requests
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ready  = 1'b0;
      wcnt       = 0;
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("hold_we", 32'(mem_we), 32'(held_we));
        check("hold_addr", 32'(mem_addr), 32'(held_addr));
        check("hold_wdata", 32'(mem_wdata), 32'(held_wdata));
      end
      if (mem_ready) wcnt = 0;
      if (mem_addr == stall_addr) mem_ready = 1'b0;
      else if (wcnt >= wait_cycles) mem_ready = 1'b1;
      else begin mem_ready = 1'b0; wcnt++; end
      hold_valid = !mem_ready;
      held_we = mem_we; held_addr = mem_addr; held_wdata = mem_wdata;
      if (mem_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_unexpected: got addr 0x%0h we %0b expected no request", mem_addr, mem_we);
        end
        if (exp_q.size() > 0) begin
          txn_t e;
          e = exp_q.pop_front();
          check("txn_we", 32'(mem_we), 32'(e.we));
          check("txn_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) check("txn_wdata", 32'(mem_wdata), 32'(e.wdata));
          if (mem_we) mem[mem_addr[9:0]] = mem_wdata;
        end
      end
    end
  end

  task automatic start_prog();
    rst_n = 1'b0;
    exp_q.delete();
    stall_addr = NO_STALL;
    for (int i = 0; i < 1024; i++) mem[i] = NOP;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, output int cycles);
    cycles = 0;
    while (halted !== 1'b1 && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  task automatic basic_prog();
    mem[0] = ins_i(O_LOADI, 5'd1, 6'd5);
    mem[1] = ins_i(O_LOADI, 5'd2, 6'd3);
    mem[2] = ins_r(O_ADD, 5'd1, 5'd2);
    mem[3] = ins_j(O_HALT, 11'd0);
    for (int i = 0; i < 4; i++) push_txn(1'b0, 24'(i), 16'h0);
  endtask

  initial begin
    // Reset state
    start_prog();
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc_o), 32'd0);

    // Basic program, zero wait
    wait_cycles = 0;
    basic_prog();
    release_reset();
    run_to_halt("t1_halt", c1);
    repeat (3) @(negedge clk);
    check("t1_r1", 32'(dut.u_regfile.regs[1]), 32'd8);
    check("t1_r2", 32'(dut.u_regfile.regs[2]), 32'd3);
    check("t1_pc", 32'(pc_o), 32'd4);
    check("t1_req", 32'(mem_req), 32'd0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Same program, two wait cycles per request
    start_prog();
    wait_cycles = 2;
    basic_prog();
    release_reset();
    run_to_halt("t2_halt", c2);
    check("t2_r1", 32'(dut.u_regfile.regs[1]), 32'd8);
    check("t2_latency", 32'(c2), 32'(c1 + 8));
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Signed compare: 0x7FFFFF vs 0xFFFFFF
    start_prog();
    wait_cycles = 0;
    mem[0] = ins_i(O_LOADI, 5'd2, 6'd0);
    mem[1] = ins_i(O_LOADI, 5'd3, 6'd1);
    mem[2] = ins_r(O_SUB, 5'd2, 5'd3);
    mem[3] = ins_r(O_MOV, 5'd1, 5'd2);
    mem[4] = ins_i(O_SHRLI, 5'd1, 6'd1);
    mem[5] = ins_r(O_CMP, 5'd1, 5'd2);
    mem[6] = ins_j(O_JUMPL, 11'h010);
    mem[7] = ins_j(O_JUMPG, 11'h020);
    mem[8] = ins_j(O_HALT, 11'd0);
    mem[16'h10] = ins_j(O_HALT, 11'd0);
    mem[16'h20] = ins_j(O_HALT, 11'd0);
    for (int i = 0; i < 8; i++) push_txn(1'b0, 24'(i), 16'h0);
    push_txn(1'b0, 24'h20, 16'h0);
    release_reset();
    run_to_halt("t3_halt", c2);
    check("t3_r1", 32'(dut.u_regfile.regs[1]), 32'h7FFFFF);
    check("t3_r2", 32'(dut.u_regfile.regs[2]), 32'hFFFFFF);
    check("t3_sf", 32'(dut.sf_q), 32'd1);
    check("t3_zf", 32'(dut.zf_q), 32'd0);
    check("t3_of", 32'(dut.of_q), 32'd1);
    check("t3_pc", 32'(pc_o), 32'h21);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Link and return, plus shift boundaries
    start_prog();
    mem[0] = ins_i(O_LOADI, 5'd4, 6'd1);
    mem[1] = ins_i(O_SHLLI, 5'd4, 6'd30);
    mem[2] = ins_i(O_LOADI, 5'd6, 6'd1);
    mem[3] = ins_i(O_SHLLI, 5'd6, 6'd23);
    mem[4] = ins_j(O_JUMPLI, 11'h020);
    mem[5] = ins_j(O_HALT, 11'd0);
    mem[16'h20] = ins_j(O_RET, 11'd0);
    for (int i = 0; i < 5; i++) push_txn(1'b0, 24'(i), 16'h0);
    push_txn(1'b0, 24'h20, 16'h0);
    push_txn(1'b0, 24'd5, 16'h0);
    release_reset();
    run_to_halt("t4_halt", c2);
    check("t4_link", 32'(dut.link_q), 32'd5);
    check("t4_shl_big", 32'(dut.u_regfile.regs[4]), 32'd0);
    check("t4_shl_23", 32'(dut.u_regfile.regs[6]), 32'h800000);
    check("t4_pc", 32'(pc_o), 32'd6);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Store then load, one wait cycle per request
    start_prog();
    wait_cycles = 1;
    mem[0]  = ins_i(O_LOADI, 5'd3, 6'd1);
    mem[1]  = ins_i(O_SHLLI, 5'd3, 6'd8);
    mem[2]  = ins_i(O_LOADI, 5'd4, 6'h2A);
    mem[3]  = ins_i(O_SHLLI, 5'd4, 6'd6);
    mem[4]  = ins_i(O_LOADI, 5'd7, 6'h3C);
    mem[5]  = ins_r(O_ADD, 5'd4, 5'd7);
    mem[6]  = ins_i(O_SHLLI, 5'd4, 6'd4);
    mem[7]  = ins_i(O_LOADI, 5'd7, 6'hD);
    mem[8]  = ins_r(O_ADD, 5'd4, 5'd7);
    mem[9]  = ins_r(O_STORE, 5'd3, 5'd4);
    mem[10] = ins_r(O_LOAD, 5'd5, 5'd3);
    mem[11] = ins_j(O_HALT, 11'd0);
    mem[16'h100] = 16'h0000;
    for (int i = 0; i < 10; i++) push_txn(1'b0, 24'(i), 16'h0);
    push_txn(1'b1, 24'h100, 16'hABCD);
    push_txn(1'b0, 24'd10, 16'h0);
    push_txn(1'b0, 24'h100, 16'h0);
    push_txn(1'b0, 24'd11, 16'h0);
    release_reset();
    run_to_halt("t5_halt", c2);
    check("t5_r4", 32'(dut.u_regfile.regs[4]), 32'hABCD);
    check("t5_r5", 32'(dut.u_regfile.regs[5]), 32'h00ABCD);
    check("t5_mem", 32'(mem[16'h100]), 32'hABCD);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during a stalled fetch at PC=7
    start_prog();
    wait_cycles = 0;
    mem[0] = ins_i(O_LOADI, 5'd1, 6'd9);
    stall_addr = 24'd7;
    for (int i = 0; i < 7; i++) push_txn(1'b0, 24'(i), 16'h0);
    release_reset();
    c2 = 0;
    while (!(mem_req === 1'b1 && mem_addr === 24'd7) && c2 < 200) begin
      @(negedge clk);
      c2++;
    end
    repeat (3) @(negedge clk);
    check("t6_stall_req", 32'(mem_req), 32'd1);
    check("t6_stall_addr", 32'(mem_addr), 32'd7);
    check("t6_r1_before", 32'(dut.u_regfile.regs[1]), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req_drop", 32'(mem_req), 32'd0);
    check("t6_pc_rst", 32'(pc_o), 32'd0);
    check("t6_r1_clr", 32'(dut.u_regfile.regs[1]), 32'd0);
    exp_q.delete();
    stall_addr = NO_STALL;
    mem[1] = ins_j(O_HALT, 11'd0);
    push_txn(1'b0, 24'd0, 16'h0);
    push_txn(1'b0, 24'd1, 16'h0);
    release_reset();
    run_to_halt("t6_halt", c2);
    check("t6_r1_after", 32'(dut.u_regfile.regs[1]), 32'd9);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
